// File: rtl/tone_synth.sv
// tone_synth: one voice turning a half-period note word into a square wave,
// shaped by an ADSR envelope and gated through a PWM for the speaker pin.
module tone_synth #(
    parameter logic [15:0] ENV_DIV      = 16'd50000,
    parameter logic [7:0]  ATTACK_STEP  = 8'd16,
    parameter logic [7:0]  DECAY_STEP   = 8'd2,
    parameter logic [7:0]  SUSTAIN_LVL  = 8'd160,
    parameter logic [7:0]  RELEASE_STEP = 8'd4,
    parameter logic [15:0] MIN_PERIOD   = 16'd16
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic [15:0] note_in,
    input  logic        enable,
    output logic        tone_out,
    output logic        audio_out,
    output logic [7:0]  level,
    output logic        active
);
    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

    state_t      r_state;
    state_t      w_dest;
    state_t      w_state_nxt;
    logic [15:0] r_note_q;
    logic [15:0] r_per;
    logic [15:0] r_per_next;
    logic [15:0] r_cnt;
    logic [15:0] r_env_cnt;
    logic [7:0]  r_pwm_cnt;
    logic [7:0]  r_level;
    logic [7:0]  w_level_nxt;
    logic        r_phase;
    logic        w_valid;
    logic        w_tick;
    logic        w_retrig;
    logic [8:0]  w_att9;
    logic [8:0]  w_dec9;
    logic [8:0]  w_rel9;

    assign w_valid  = enable && (r_note_q >= MIN_PERIOD);
    assign w_tick   = (r_env_cnt == ENV_DIV - 16'd1);
    assign w_retrig = w_valid && (r_note_q != r_per_next);

    // Nine-bit envelope math so overflow/borrow shows up in bit 8 before clamping.
    assign w_att9 = {1'b0, r_level} + {1'b0, ATTACK_STEP};
    assign w_dec9 = {1'b0, r_level} - {1'b0, DECAY_STEP};
    assign w_rel9 = {1'b0, r_level} - {1'b0, RELEASE_STEP};

    // Pick the destination state first; a coincident tick applies that state's step once.
    always_comb begin
        w_dest = r_state;
        if (w_retrig || (r_state == RELEASE && w_valid))
            w_dest = ATTACK;
        else if (r_state != RELEASE && !w_valid)
            w_dest = RELEASE;

        w_state_nxt = w_dest;
        w_level_nxt = r_level;
        if (w_tick) begin
            case (w_dest)
                ATTACK: begin
                    w_level_nxt = w_att9[8] ? 8'hFF : w_att9[7:0];
                    if (w_level_nxt == 8'hFF) w_state_nxt = DECAY;
                end
                DECAY: begin
                    w_level_nxt = (w_dec9[8] || w_dec9[7:0] < SUSTAIN_LVL) ? SUSTAIN_LVL : w_dec9[7:0];
                    if (w_level_nxt == SUSTAIN_LVL) w_state_nxt = SUSTAIN;
                end
                RELEASE: begin
                    w_level_nxt = w_rel9[8] ? 8'd0 : w_rel9[7:0];
                    if (w_level_nxt == 8'd0) w_state_nxt = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            r_note_q   <= '0;
            r_env_cnt  <= '0;
            r_pwm_cnt  <= '0;
            r_state    <= IDLE;
            r_per      <= '0;
            r_per_next <= '0;
            r_cnt      <= '0;
            r_phase    <= 1'b0;
            r_level    <= '0;
        end else begin
            r_note_q  <= note_in;
            r_env_cnt <= w_tick ? 16'd0 : r_env_cnt + 16'd1;
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            if (r_state == IDLE) begin
                if (w_valid) begin
                    r_per      <= r_note_q;
                    r_per_next <= r_note_q;
                    r_cnt      <= '0;
                    r_phase    <= 1'b1;
                    r_state    <= ATTACK;
                end
            end else begin
                // Period changes land only at a half-period boundary, so no runt pulses.
                if (r_cnt == r_per - 16'd1) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                    r_per   <= r_per_next;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
                if (w_retrig) r_per_next <= r_note_q;
                r_state <= w_state_nxt;
                r_level <= w_level_nxt;
                if (w_state_nxt == IDLE) begin
                    r_phase <= 1'b0;
                    r_cnt   <= '0;
                end
            end
        end
    end

    assign tone_out  = r_phase;
    assign audio_out = r_phase && (r_pwm_cnt < r_level);
    assign level     = r_level;
    assign active    = (r_state != IDLE);

endmodule

// File: tb/tb_tone_synth.sv
// Bench for tone_synth: directed scenarios plus random note/gate traffic,
// every cycle compared against a behavioural voice model.
module tb_tone_synth;
    localparam int ENV_DIV = 4;
    localparam int AS      = 16;
    localparam int DS      = 2;
    localparam int SL      = 128;
    localparam int RS      = 4;
    localparam int MINP    = 16;
    localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

    logic        clk50 = 1'b0;
    logic        reset;
    logic [15:0] note_in;
    logic        enable;
    logic        tone_out;
    logic        audio_out;
    logic [7:0]  level;
    logic        active;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    tone_synth #(
        .ENV_DIV     (16'(ENV_DIV)),
        .ATTACK_STEP (8'(AS)),
        .DECAY_STEP  (8'(DS)),
        .SUSTAIN_LVL (8'(SL)),
        .RELEASE_STEP(8'(RS)),
        .MIN_PERIOD  (16'(MINP))
    ) dut (
        .clk50    (clk50),
        .reset    (reset),
        .note_in  (note_in),
        .enable   (enable),
        .tone_out (tone_out),
        .audio_out(audio_out),
        .level    (level),
        .active   (active)
    );

    always #5 clk50 = ~clk50;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural voice: time left in the current half-period plus envelope level.
    int m_st, m_lvl, m_rem, m_pnext, m_nq, m_env, m_pwm, m_ph;
    int nq, ns;
    bit m_v, m_t;

    always @(posedge clk50) begin
        if (reset) begin
            m_st = S_IDLE; m_lvl = 0; m_rem = 0; m_pnext = 0;
            m_nq = 0; m_env = 0; m_pwm = 0; m_ph = 0;
        end else begin
            m_v   = enable && (m_nq >= MINP);
            m_t   = (m_env == ENV_DIV - 1);
            nq    = m_nq;
            m_nq  = int'(note_in);
            m_env = m_t ? 0 : m_env + 1;
            m_pwm = (m_pwm + 1) % 256;
            if (m_st == S_IDLE) begin
                if (m_v) begin
                    m_pnext = nq; m_rem = nq; m_ph = 1; m_st = S_ATT;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_ph  = 1 - m_ph;
                    m_rem = m_pnext;
                end
                ns = m_st;
                if (m_v && nq != m_pnext) begin
                    m_pnext = nq; ns = S_ATT;
                end else if (m_st == S_REL && m_v) ns = S_ATT;
                else if (m_st != S_REL && !m_v) ns = S_REL;
                if (m_t) begin
                    case (ns)
                        S_ATT: begin
                            m_lvl = (m_lvl + AS > 255) ? 255 : m_lvl + AS;
                            if (m_lvl == 255) ns = S_DEC;
                        end
                        S_DEC: begin
                            m_lvl = (m_lvl - DS < SL) ? SL : m_lvl - DS;
                            if (m_lvl == SL) ns = S_SUS;
                        end
                        S_REL: begin
                            m_lvl = (m_lvl - RS < 0) ? 0 : m_lvl - RS;
                            if (m_lvl == 0) begin
                                ns = S_IDLE; m_ph = 0; m_rem = 0;
                            end
                        end
                        default: ;
                    endcase
                end
                m_st = ns;
            end
        end
    end

    always @(negedge clk50) begin
        if (chk_en) begin
            chk("tone",   int'(tone_out),  m_ph);
            chk("audio",  int'(audio_out), int'(m_ph == 1 && m_pwm < m_lvl));
            chk("level",  int'(level),     m_lvl);
            chk("active", int'(active),    int'(m_st != S_IDLE));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk50);
    endtask

    initial begin
        int found;
        reset = 1'b1; note_in = '0; enable = 1'b0;
        @(posedge clk50);
        @(negedge clk50);
        chk_en = 1'b1;
        chk("rst_level", int'(level), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_audio", int'(audio_out), 0);
        reset = 1'b0;
        idle(3);

        // Note 100: tone rises two edges after the note is applied.
        note_in = 16'd100; enable = 1'b1;
        idle(1);
        chk("lat_pre", int'(tone_out), 0);
        idle(1);
        chk("lat_tone", int'(tone_out), 1);
        chk("lat_active", int'(active), 1);
        idle(500);
        chk("sus_level", int'(level), SL);

        // Mid-half-period change 100 -> 50 at cnt == 30.
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            if (m_rem == 70) found = 1;
            else idle(1);
        end
        chk("cnt30_found", found, 1);
        note_in = 16'd50;
        idle(600);
        chk("retrig_sus", int'(level), SL);

        // Rest during sustain: release to idle.
        note_in = 16'd0;
        idle(200);
        chk("rel_level", int'(level), 0);
        chk("rel_active", int'(active), 0);
        chk("rel_tone", int'(tone_out), 0);

        // Below-minimum period never starts a note.
        note_in = 16'd8;
        idle(300);
        chk("short_active", int'(active), 0);

        // Reset during attack.
        note_in = 16'd100;
        idle(30);
        reset = 1'b1;
        idle(1);
        chk("rst_mid_level", int'(level), 0);
        chk("rst_mid_tone", int'(tone_out), 0);
        chk("rst_mid_active", int'(active), 0);
        reset = 1'b0;
        idle(100);

        // Long period with PWM visible in audio_out.
        note_in = 16'd1000;
        idle(2200);

        // Random traffic: notes, rests, short periods, gate drops, resets.
        repeat (30) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) note_in = 16'd0;
            else if (r < 3) note_in = 16'($urandom_range(1, 15));
            else note_in = 16'($urandom_range(16, 120));
            enable = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 14) == 0) begin
                reset = 1'b1;
                idle(1);
                reset = 1'b0;
            end
            idle($urandom_range(1, 300));
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule
